// File: rtl/snoop_pkg.sv
// Shared constants and types for the ACE snoop dispatcher: snoop encodings,
// CRRESP bit positions and the dispatcher FSM state encoding.
package snoop_pkg;

    localparam int unsigned LINE_BEATS = 16;

    localparam logic [3:0] SnoopReadShared  = 4'b0001;
    localparam logic [3:0] SnoopReadUnique  = 4'b0111;
    localparam logic [3:0] SnoopMakeInvalid = 4'b1101;

    localparam int unsigned RespDataTransfer = 0;
    localparam int unsigned RespError        = 1;
    localparam int unsigned RespPassDirty    = 2;
    localparam int unsigned RespIsShared     = 3;
    localparam int unsigned RespWasUnique    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StAcReq,
        StCrWait,
        StCdCollect,
        StRsp,
        StDataOut
    } state_e;

endpackage

// File: rtl/snoop_line_buffer.sv
// Line buffer for one snooped cache line: single write port, asynchronous read port.
// Storage is deliberately not reset; stale beats are simply overwritten by the next line.
module snoop_line_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/snoop_dispatcher.sv
// ACE snoop-channel master toward one peer L1: issues a single snoop on AC, collects the
// CR response and optional CD line, then returns the summary and buffered line to the requester.
module snoop_dispatcher
    import snoop_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEATS  = LINE_BEATS
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_snoop,
    input  logic [2:0]        req_prot,
    output logic              ACVALID,
    input  logic              ACREADY,
    output logic [ADDR_W-1:0] ACADDR,
    output logic [3:0]        ACSNOOP,
    output logic [2:0]        ACPROT,
    input  logic              CRVALID,
    output logic              CRREADY,
    input  logic [4:0]        CRRESP,
    input  logic              CDVALID,
    output logic              CDREADY,
    input  logic [DATA_W-1:0] CDDATA,
    input  logic              CDLAST,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_resp,
    output logic              rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        snoop_q;
    logic [2:0]        prot_q;
    logic [4:0]        resp_q;
    logic              err_q;
    logic [3:0]        cnt_q;
    logic [3:0]        rd_q;

    logic cd_fire;
    logic cd_end;

    assign cd_fire = (state_q == StCdCollect) && CDVALID;
    assign cd_end  = cd_fire && (CDLAST || (cnt_q == 4'd15));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (req_valid) state_d = StAcReq;
            StAcReq:     if (ACREADY) state_d = StCrWait;
            StCrWait: begin
                if (CRVALID) begin
                    state_d = CRRESP[RespDataTransfer] ? StCdCollect : StRsp;
                end
            end
            StCdCollect: if (cd_end) state_d = StRsp;
            StRsp: begin
                if (rsp_ready) begin
                    state_d = resp_q[RespDataTransfer] ? StDataOut : StIdle;
                end
            end
            StDataOut:   if (out_ready && (rd_q == 4'd15)) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        ACVALID   = 1'b0;
        CRREADY   = 1'b0;
        CDREADY   = 1'b0;
        rsp_valid = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state_q)
            StIdle:      req_ready = 1'b1;
            StAcReq:     ACVALID   = 1'b1;
            StCrWait:    CRREADY   = 1'b1;
            StCdCollect: CDREADY   = 1'b1;
            StRsp:       rsp_valid = 1'b1;
            StDataOut: begin
                out_valid = 1'b1;
                out_last  = (rd_q == 4'd15);
            end
            default: ;
        endcase
    end

    // AC payload comes straight from the latch so it stays stable while the peer forms CRRESP
    assign ACADDR   = addr_q;
    assign ACSNOOP  = snoop_q;
    assign ACPROT   = prot_q;
    assign rsp_resp = resp_q;
    assign rsp_err  = resp_q[RespError] | err_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            snoop_q <= '0;
            prot_q  <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            if ((state_q == StIdle) && req_valid) begin
                addr_q  <= req_addr;
                snoop_q <= req_snoop;
                prot_q  <= req_prot;
                err_q   <= 1'b0;
                rd_q    <= '0;
            end
            if ((state_q == StCrWait) && CRVALID) begin
                resp_q <= CRRESP;
                cnt_q  <= '0;
            end
            if (cd_fire) begin
                cnt_q <= cnt_q + 4'd1;
                // Early or missing CDLAST is a peer protocol violation; the line still completes
                if (CDLAST != (cnt_q == 4'd15)) begin
                    err_q <= 1'b1;
                end
            end
            if ((state_q == StDataOut) && out_ready) begin
                rd_q <= rd_q + 4'd1;
            end
        end
    end

    snoop_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (BEATS)
    ) u_line_buffer (
        .clk   (ACLK),
        .we    (cd_fire),
        .waddr (cnt_q),
        .wdata (CDDATA),
        .raddr (rd_q),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_snoop_dispatcher.sv
// Directed bench for snoop_dispatcher: drives request/AC/CR/CD handshakes step by step and
// checks response summaries and line beats against scoreboard queues filled at stimulus time.
module tb_snoop_dispatcher;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_snoop;
    logic [2:0]  req_prot;
    logic        ACVALID;
    logic        ACREADY;
    logic [31:0] ACADDR;
    logic [3:0]  ACSNOOP;
    logic [2:0]  ACPROT;
    logic        CRVALID;
    logic        CRREADY;
    logic [4:0]  CRRESP;
    logic        CDVALID;
    logic        CDREADY;
    logic [31:0] CDDATA;
    logic        CDLAST;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_resp;
    logic        rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    snoop_dispatcher #(
        .ADDR_W (32),
        .DATA_W (32),
        .BEATS  (16)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_snoop (req_snoop),
        .req_prot  (req_prot),
        .ACVALID   (ACVALID),
        .ACREADY   (ACREADY),
        .ACADDR    (ACADDR),
        .ACSNOOP   (ACSNOOP),
        .ACPROT    (ACPROT),
        .CRVALID   (CRVALID),
        .CRREADY   (CRREADY),
        .CRRESP    (CRRESP),
        .CDVALID   (CDVALID),
        .CDREADY   (CDREADY),
        .CDDATA    (CDDATA),
        .CDLAST    (CDLAST),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_resp  (rsp_resp),
        .rsp_err   (rsp_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [5:0]  rsp_q [$];   // {rsp_err, rsp_resp}
    logic [31:0] out_q [$];
    logic [31:0] exp_buf [16];
    logic [31:0] cur_addr;
    logic [3:0]  cur_snoop;
    logic [2:0]  cur_prot;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_acvalid"}, ACVALID, 0);
        check({tag, "_crready"}, CRREADY, 0);
        check({tag, "_cdready"}, CDREADY, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_out_valid"}, out_valid, 0);
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [3:0] snoop, input logic [2:0] prot);
        req_valid = 1'b1;
        req_addr  = addr;
        req_snoop = snoop;
        req_prot  = prot;
        cur_addr  = addr;
        cur_snoop = snoop;
        cur_prot  = prot;
        check("req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        req_addr  = 32'hdead_beef;
        req_snoop = 4'hf;
        req_prot  = 3'h7;
    endtask

    // Stray CRVALID with garbage is held during AC wait cycles and must be ignored
    task automatic ac_phase(input int delay);
        for (int i = 0; i <= delay; i++) begin
            ACREADY = (i == delay);
            CRVALID = (i < delay);
            CRRESP  = 5'h1f;
            check("acvalid", ACVALID, 1);
            check("acaddr", ACADDR, cur_addr);
            check("acsnoop", ACSNOOP, cur_snoop);
            check("acprot", ACPROT, cur_prot);
            check("crready_ac", CRREADY, 0);
            step();
        end
        ACREADY = 1'b0;
        CRVALID = 1'b0;
    endtask

    task automatic cr_phase(input int delay, input logic [4:0] resp);
        for (int i = 0; i < delay; i++) begin
            check("crready_wait", CRREADY, 1);
            check("acvalid_cr", ACVALID, 0);
            check("cdready_cr", CDREADY, 0);
            check("acsnoop_cr", ACSNOOP, cur_snoop);
            check("acaddr_cr", ACADDR, cur_addr);
            step();
        end
        CRVALID = 1'b1;
        CRRESP  = resp;
        check("crready", CRREADY, 1);
        check("acsnoop_crhs", ACSNOOP, cur_snoop);
        step();
        CRVALID = 1'b0;
        CRRESP  = 5'h0;
        if (!resp[0]) rsp_q.push_back({resp[1], resp});
    endtask

    // last_at < 0 means CDLAST is never raised
    task automatic cd_phase(input logic [4:0] resp, input int last_at, input bit gaps,
                            input logic [31:0] base);
        bit err = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (gaps && (b % 3 == 1)) begin
                CDVALID = 1'b0;
                check("cdready_gap", CDREADY, 1);
                step();
            end
            CDVALID = 1'b1;
            CDDATA  = base + b;
            CDLAST  = (b == last_at);
            check("cdready", CDREADY, 1);
            check("rsp_valid_cd", rsp_valid, 0);
            exp_buf[b] = base + b;
            if ((b == last_at) != (b == 15)) err = 1'b1;
            step();
            if (b == last_at) break;
        end
        CDVALID = 1'b0;
        CDLAST  = 1'b0;
        rsp_q.push_back({err | resp[1], resp});
        for (int i = 0; i < 16; i++) out_q.push_back(exp_buf[i]);
    endtask

    task automatic data_phase(input bit toggle);
        for (int c = 0; c < 64 && out_q.size() > 0; c++) begin
            logic [31:0] e;
            bit rdy;
            rdy = toggle ? (c % 2 == 0) : 1'b1;
            out_ready = rdy;
            e = out_q[0];
            check("out_valid", out_valid, 1);
            check("out_data", out_data, e);
            check("out_last", out_last, out_q.size() == 1);
            step();
            if (rdy) void'(out_q.pop_front());
        end
        out_ready = 1'b0;
        check("out_drained", out_q.size(), 0);
    endtask

    task automatic rsp_phase(input bit has_data, input bit toggle);
        logic [5:0] e;
        check("rsp_valid", rsp_valid, 1);
        check("cdready_rsp", CDREADY, 0);
        check("out_valid_rsp", out_valid, 0);
        check("rsp_q_nonempty", rsp_q.size() > 0, 1);
        e = (rsp_q.size() > 0) ? rsp_q.pop_front() : 6'h3f;
        check("rsp_resp", rsp_resp, e[4:0]);
        check("rsp_err", rsp_err, e[5]);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (has_data) data_phase(toggle);
        check_idle("end");
    endtask

    task automatic txn(input logic [31:0] addr, input logic [3:0] snoop, input logic [2:0] prot,
                       input int ac_d, input int cr_d, input logic [4:0] resp,
                       input int last_at, input bit gaps, input logic [31:0] base,
                       input bit toggle);
        do_req(addr, snoop, prot);
        ac_phase(ac_d);
        cr_phase(cr_d, resp);
        if (resp[0]) cd_phase(resp, last_at, gaps, base);
        rsp_phase(resp[0], toggle);
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_snoop = '0;
        req_prot  = '0;
        ACREADY   = 1'b0;
        CRVALID   = 1'b0;
        CRRESP    = '0;
        CDVALID   = 1'b0;
        CDDATA    = '0;
        CDLAST    = 1'b0;
        rsp_ready = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check_idle("reset");
        check("reset_rsp_resp", rsp_resp, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_acsnoop", ACSNOOP, 0);
        ARESETn = 1'b1;
        step();

        // 1: ReadShared with full clean line
        txn(32'h1000, 4'b0001, 3'b010, 0, 0, 5'b01001, 15, 1'b0, 32'hA0, 1'b0);
        // 2: MakeInvalid, no data phase
        txn(32'h2040, 4'b1101, 3'b000, 0, 0, 5'b10000, 15, 1'b0, 32'h0, 1'b0);
        // 3: slow AC and CR handshakes, ReadUnique payload must stay stable
        txn(32'h3080, 4'b0111, 3'b001, 3, 5, 5'b01000, 15, 1'b0, 32'h0, 1'b0);
        // 4: CD gaps with out_ready toggling
        txn(32'h40c0, 4'b0001, 3'b011, 1, 1, 5'b00101, 15, 1'b1, 32'hB0, 1'b1);
        // 5: early CDLAST on beat 10; beats 11..15 stay stale from the previous line
        txn(32'h5100, 4'b0001, 3'b000, 0, 0, 5'b00001, 10, 1'b0, 32'hC0, 1'b0);
        // Error bit in CRRESP without data
        txn(32'h5140, 4'b0111, 3'b000, 0, 2, 5'b00010, 15, 1'b0, 32'h0, 1'b0);
        // Beat 15 arrives without CDLAST
        txn(32'h5180, 4'b0001, 3'b000, 0, 0, 5'b00001, -1, 1'b0, 32'hD0, 1'b0);

        // 6: reset during CD beat 7
        do_req(32'h6000, 4'b0001, 3'b000);
        ac_phase(0);
        CRVALID = 1'b1;
        CRRESP  = 5'b00001;
        step();
        CRVALID = 1'b0;
        for (int b = 0; b < 7; b++) begin
            CDVALID = 1'b1;
            CDDATA  = 32'hE0 + b;
            exp_buf[b] = 32'hE0 + b;
            step();
        end
        CDVALID = 1'b0;
        check("cdready_pre_reset", CDREADY, 1);
        ARESETn = 1'b0;
        #1;
        check_idle("midreset");
        check("midreset_rsp_resp", rsp_resp, 0);
        step();
        ARESETn = 1'b1;
        step();
        check_idle("post_reset");
        txn(32'h7000, 4'b0001, 3'b101, 0, 1, 5'b01001, 15, 1'b0, 32'hF0, 1'b0);

        check("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
